// File: rtl/jt900h_busrsp_pkg.sv
// rtl/jt900h_busrsp_pkg.sv - shared states, target codes, timeout limit and address decode for jt900h_busrsp
package jt900h_busrsp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IRAM = 2'd1,
      ST_EXT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic {
      TGT_IRAM = 1'b0,
      TGT_EXT  = 1'b1
   } target_t;

   localparam logic [7:0] TMO_LIMIT = 8'd255;

   // IRAM hit when every byte-address bit above the RAM span matches the base
   function automatic target_t decode(input logic [23:0] addr, input logic [23:0] base,
                                      input int aw);
      logic [23:0] mask;
      mask = ~((24'd1 << (aw + 1)) - 24'd1);
      return (((addr ^ base) & mask) == 24'd0) ? TGT_IRAM : TGT_EXT;
   endfunction

endpackage

// File: rtl/jt900h_iram.sv
// rtl/jt900h_iram.sv - single-port 16-bit RAM with byte enables and one-cycle read latency
module jt900h_iram #(
   parameter int AW = 11
)(
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   din,
   input  logic [1:0]    we,
   output logic [15:0]   dout
);

   logic [15:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we[0]) mem[addr][7:0]  <= din[7:0];
      if (we[1]) mem[addr][15:8] <= din[15:8];
      dout <= mem[addr];
   end

endmodule

// File: rtl/jt900h_busrsp.sv
// rtl/jt900h_busrsp.sv - JT900H bus responder: IRAM/EXT decode and cpu_cen pacing; JT900H_BUSRSP_TIMEOUT_EN adds EXT timeout
module jt900h_busrsp
   import jt900h_busrsp_pkg::*;
#(
   parameter int          IRAM_AW   = 11,
   parameter logic [23:0] IRAM_BASE = 24'h004000,
   parameter int          EXT_WAIT  = 2
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] cpu_addr,
   input  logic [15:0] cpu_din,
   input  logic [1:0]  cpu_we,
   input  logic        cpu_rd,
   output logic [15:0] cpu_dout,
   output logic        cpu_cen,
   output logic [22:0] ext_addr,
   output logic [15:0] ext_din,
   output logic [1:0]  ext_we,
   output logic        ext_cs,
   input  logic [15:0] ext_dout,
   input  logic        ext_ok,
   output logic        bus_err
);

   state_t             st;
   logic [22:0]        last_word;
   logic               prev_rd;
   logic               rd_l;
   logic               ok_l;
   logic [15:0]        ext_data;
   logic [7:0]         wait_cnt;
   logic [IRAM_AW-1:0] addr_l;
   logic [15:0]        din_l;
   logic [1:0]         we_l;
   logic [IRAM_AW-1:0] ram_addr;
   logic [1:0]         ram_we;
   logic [15:0]        ram_q;
   logic               is_wr;
   logic               is_rd;
   target_t            tgt;
   logic               unused_addr0;

`ifdef JT900H_BUSRSP_TIMEOUT_EN
   logic [7:0]         tmo_cnt;
   logic               bus_err_r;
   assign bus_err = bus_err_r;
`else
   assign bus_err = 1'b0;
`endif

   assign unused_addr0 = cpu_addr[0];
   assign is_wr = cpu_we != 2'b00;
   assign is_rd = cpu_rd && (!prev_rd || cpu_addr[23:1] != last_word);
   assign tgt   = decode(cpu_addr, IRAM_BASE, IRAM_AW);

   // The RAM sees the live bus while idle so read data is ready during the IRAM cycle
   assign ram_addr = (st == ST_IDLE) ? cpu_addr[IRAM_AW:1] : addr_l;
   assign ram_we   = (st == ST_IRAM && !rd_l) ? we_l : 2'b00;

   jt900h_iram #(.AW(IRAM_AW)) u_iram (
      .clk  (clk),
      .addr (ram_addr),
      .din  (din_l),
      .we   (ram_we),
      .dout (ram_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= ST_IDLE;
         cpu_cen   <= 1'b0;
         cpu_dout  <= 16'h0000;
         ext_cs    <= 1'b0;
         ext_we    <= 2'b00;
         ext_addr  <= 23'd0;
         ext_din   <= 16'h0000;
         last_word <= '1;
         prev_rd   <= 1'b0;
         rd_l      <= 1'b0;
         ok_l      <= 1'b0;
         ext_data  <= 16'h0000;
         wait_cnt  <= 8'd0;
         addr_l    <= '0;
         din_l     <= 16'h0000;
         we_l      <= 2'b00;
`ifdef JT900H_BUSRSP_TIMEOUT_EN
         tmo_cnt   <= 8'd0;
         bus_err_r <= 1'b0;
`endif
      end else begin
         case (st)
            ST_IDLE: begin
               if (!cpu_cen) begin
                  cpu_cen <= 1'b1;
               end else begin
                  prev_rd <= cpu_rd;
                  if (is_wr || is_rd) begin
                     cpu_cen <= 1'b0;
                     rd_l    <= !is_wr;
                     addr_l  <= cpu_addr[IRAM_AW:1];
                     din_l   <= cpu_din;
                     we_l    <= cpu_we;
                     if (!is_wr) last_word <= cpu_addr[23:1];
                     if (tgt == TGT_IRAM) begin
                        st <= ST_IRAM;
                     end else begin
                        st       <= ST_EXT;
                        ext_cs   <= 1'b1;
                        ext_addr <= cpu_addr[23:1];
                        ext_din  <= cpu_din;
                        ext_we   <= cpu_we;
                        wait_cnt <= 8'(EXT_WAIT);
                        ok_l     <= 1'b0;
`ifdef JT900H_BUSRSP_TIMEOUT_EN
                        tmo_cnt  <= 8'd0;
`endif
                     end
                  end
               end
            end
            ST_IRAM: begin
               if (rd_l) cpu_dout <= ram_q;
               st <= ST_DONE;
            end
            ST_EXT: begin
               if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
               // The request is released on ext_ok; completion still waits for the counter
               if (ext_ok && !ok_l) begin
                  ok_l     <= 1'b1;
                  ext_data <= ext_dout;
                  ext_cs   <= 1'b0;
                  ext_we   <= 2'b00;
               end
               if (ok_l && wait_cnt == 8'd0) begin
                  if (rd_l) cpu_dout <= ext_data;
                  st <= ST_DONE;
               end
`ifdef JT900H_BUSRSP_TIMEOUT_EN
               else if (!ok_l && !ext_ok) begin
                  tmo_cnt <= tmo_cnt + 8'd1;
                  if (tmo_cnt == TMO_LIMIT - 8'd1) begin
                     ext_cs    <= 1'b0;
                     ext_we    <= 2'b00;
                     bus_err_r <= 1'b1;
                     if (rd_l) cpu_dout <= 16'hFFFF;
                     st <= ST_DONE;
                  end
               end
`endif
            end
            ST_DONE: begin
               cpu_cen <= 1'b1;
               st      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
